pipe_hazard_ctrl: RTL

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Watches the instruction in ID and the instruction in EX.
- Drives PC hold, IF/ID hold and flush, and the ID/EX bubble.
- Tracks the multi-cycle multiply/divide unit (MDU) with an internal countdown, and keeps saturating stall/flush event counters for the simulation monitors.

---
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage MIPS pipeline. It looks at
// the instruction sitting in ID and the load sitting in EX, decides whether the
// front end has to stall or be flushed, and tracks how long HI/LO stay busy
// after a multiply/divide issues.
//
// Parameters:
//   MDU_LATENCY  cycles HI/LO are unavailable after an MDU op issues (1..15)
//   CNT_W        width of the saturating stall/flush event counters
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_rs, id_rt      source register fields of the instruction in ID
//   id_uses_rt        ID instruction actually reads rt
//   id_branch_taken   branch/jump in ID resolved taken this cycle
//   id_mdu_op         ID instruction is mult/multu/div/divu
//   id_hilo_read      ID instruction is mfhi/mflo
//   ex_memread        EX instruction is a load
//   ex_rt             destination register of the load in EX
//   pc_en             PC load enable
//   if2id_en          IF/ID load enable
//   if2id_flush       IF/ID captures a NOP bubble
//   id2ex_flush       ID/EX captures a bubble
//   mdu_busy          MDU countdown is nonzero
//   stall_cycles      saturating count of stalled cycles
//   flush_count       saturating count of IF/ID flush cycles

module pipe_hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic             id_mdu_op,
  input  logic             id_hilo_read,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             if2id_flush,
  output logic             id2ex_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [3:0] mdu_cnt;
  logic       lu_hz;
  logic       mdu_hz;
  logic       stall;
  logic       flush;

  // Hazard detection. A load into $zero never produces a value anyone waits
  // for, so ex_rt == 0 is excluded. A new MDU op also has to wait for the
  // previous one, otherwise it would clobber HI/LO still being produced.
  // Reset forces everything open so the pipeline drains cleanly.
  always_comb begin
    lu_hz  = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdu_hz = (mdu_cnt != 4'd0) && (id_hilo_read || id_mdu_op);
    stall  = (lu_hz || mdu_hz) && !reset;
    // A stalled branch is ignored; it is re-evaluated once the stall releases.
    flush  = id_branch_taken && !stall && !reset;
  end

  assign pc_en       = ~stall;
  assign if2id_en    = ~stall;
  assign id2ex_flush = stall;
  assign if2id_flush = flush;
  assign mdu_busy    = (mdu_cnt != 4'd0);

  // MDU countdown. An op waiting behind a busy MDU lets the count keep
  // draining, then issues (and reloads) on the first cycle it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt <= 4'd0;
    end else if (id_mdu_op && !stall) begin
      mdu_cnt <= 4'(MDU_LATENCY);
    end else if (mdu_cnt != 4'd0) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end
  end

  // Event counters for the simulation monitors; they stick at all-ones
  // rather than wrapping so a long run never reports a misleadingly small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (flush && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule
